// File: rtl/wb_regfile_pkg.sv
// Constants shared between the pipeline registers and the write-back register file.
package wb_regfile_pkg;

    localparam logic RstEnable   = 1'b1;
    localparam logic WriteEnable = 1'b1;
    localparam logic ReadEnable  = 1'b1;

    localparam int REG_W      = 32;
    localparam int REG_ADDR_W = 5;
    localparam int RegNum     = 32;

    typedef logic [REG_W-1:0]      RegBus;
    typedef logic [REG_ADDR_W-1:0] RegAddrBus;

    localparam RegBus     ZeroWord   = '0;
    localparam RegAddrBus NOPRegAddr = '0;

endpackage

// File: rtl/wb_regfile_hilo_reg.sv
// HI/LO special-register pair with same-cycle write-through bypass to EX.
module hilo_reg
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (rst == RstEnable) begin
            hi_d = '0;
            lo_d = '0;
        end else if (we == WriteEnable) begin
            hi_d = hi_i;
            lo_d = lo_i;
        end
    end

    always_ff @(posedge clk) begin
        hi_q <= hi_d;
        lo_q <= lo_d;
    end

    always_comb begin
        hi_o = hi_q;
        lo_o = lo_q;
        if (rst == RstEnable) begin
            hi_o = '0;
            lo_o = '0;
        end else if (we == WriteEnable) begin
            hi_o = hi_i;
            lo_o = lo_i;
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// Write-back register file: 32 GPRs with two bypassed read ports, plus the HI/LO pair.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W   = REG_W,
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int NUM_REGS = RegNum
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_wreg,
    input  logic [ADDR_W-1:0] wb_dest_addr,
    input  logic [DATA_W-1:0] wb_dest_data,
    input  logic              wb_whilo,
    input  logic [DATA_W-1:0] wb_hi,
    input  logic [DATA_W-1:0] wb_lo,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic              gpr_we;

    assign gpr_we = (wb_wreg == WriteEnable) && (wb_dest_addr != ADDR_W'(NOPRegAddr));

    always_comb begin
        regs_d = regs_q;
        if (rst == RstEnable) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_d[i] = '0;
            end
        end else if (gpr_we) begin
            regs_d[wb_dest_addr] = wb_dest_data;
        end
    end

    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

    // The enable is tested before the address so an unknown address on an idle port stays masked.
    function automatic logic [DATA_W-1:0] read_port(input logic re, input logic [ADDR_W-1:0] raddr);
        logic [DATA_W-1:0] val;
        val = '0;
        if (rst == RstEnable) begin
            val = '0;
        end else if (re != ReadEnable) begin
            val = '0;
        end else if (raddr == ADDR_W'(NOPRegAddr)) begin
            val = '0;
        end else if (gpr_we && (wb_dest_addr == raddr)) begin
            val = wb_dest_data;
        end else begin
            val = regs_q[raddr];
        end
        return val;
    endfunction

    assign rdata1 = read_port(re1, raddr1);
    assign rdata2 = read_port(re2, raddr2);

    hilo_reg #(
        .DATA_W (DATA_W)
    ) u_hilo_reg (
        .clk  (clk),
        .rst  (rst),
        .we   (wb_whilo),
        .hi_i (wb_hi),
        .lo_i (wb_lo),
        .hi_o (hi_o),
        .lo_o (lo_o)
    );

endmodule

// File: tb/tb_wb_regfile.sv
// Randomised bench for wb_regfile against an array-based model, plus directed literal checks.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_wreg;
    logic [4:0]  wb_dest_addr;
    logic [31:0] wb_dest_data;
    logic        wb_whilo;
    logic [31:0] wb_hi;
    logic [31:0] wb_lo;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk          (clk),
        .rst          (rst),
        .wb_wreg      (wb_wreg),
        .wb_dest_addr (wb_dest_addr),
        .wb_dest_data (wb_dest_data),
        .wb_whilo     (wb_whilo),
        .wb_hi        (wb_hi),
        .wb_lo        (wb_lo),
        .re1          (re1),
        .raddr1       (raddr1),
        .rdata1       (rdata1),
        .re2          (re2),
        .raddr2       (raddr2),
        .rdata2       (rdata2),
        .hi_o         (hi_o),
        .lo_o         (lo_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Model state: what the architectural registers hold after each edge.
    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_hi = 32'h0;
        m_lo = 32'h0;
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
            m_hi = 32'h0;
            m_lo = 32'h0;
        end else begin
            if (wb_wreg && wb_dest_addr != 5'd0) m_regs[wb_dest_addr] = wb_dest_data;
            if (wb_whilo) begin
                m_hi = wb_hi;
                m_lo = wb_lo;
            end
        end
    end

    function automatic logic [31:0] exp_rd(input logic re, input logic [4:0] a);
        if (rst) return 32'h0;
        if (!re) return 32'h0;
        if (a == 5'd0) return 32'h0;
        if (wb_wreg && wb_dest_addr == a) return wb_dest_data;
        return m_regs[a];
    endfunction

    function automatic logic [31:0] exp_hi();
        if (rst) return 32'h0;
        if (wb_whilo) return wb_hi;
        return m_hi;
    endfunction

    function automatic logic [31:0] exp_lo();
        if (rst) return 32'h0;
        if (wb_whilo) return wb_lo;
        return m_lo;
    endfunction

    always @(negedge clk) begin
        check("model_rdata1", rdata1, exp_rd(re1, raddr1));
        check("model_rdata2", rdata2, exp_rd(re2, raddr2));
        check("model_hi", hi_o, exp_hi());
        check("model_lo", lo_o, exp_lo());
    end

    task automatic idle();
        wb_wreg = 0; wb_dest_addr = 0; wb_dest_data = 0;
        wb_whilo = 0; wb_hi = 0; wb_lo = 0;
        re1 = 0; raddr1 = 0; re2 = 0; raddr2 = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1;
        idle();

        // Reset with a pending write: write lost, outputs forced low.
        wb_wreg = 1; wb_dest_addr = 5; wb_dest_data = 32'hDEADBEEF;
        re1 = 1; raddr1 = 5;
        #1;
        @(negedge clk);
        check("rst_rdata1", rdata1, 32'h0);
        next_cycle();
        next_cycle();
        rst = 0; wb_wreg = 0;
        @(negedge clk);
        check("post_rst_rdata1", rdata1, 32'h0);
        check("post_rst_hi", hi_o, 32'h0);
        check("post_rst_lo", lo_o, 32'h0);

        // Write then read on both ports.
        next_cycle();
        idle();
        wb_wreg = 1; wb_dest_addr = 3; wb_dest_data = 32'h12345678;
        next_cycle();
        idle();
        re1 = 1; raddr1 = 3; re2 = 1; raddr2 = 3;
        @(negedge clk);
        check("wr_rd_p1", rdata1, 32'h12345678);
        check("wr_rd_p2", rdata2, 32'h12345678);
        next_cycle();
        re2 = 0;
        @(negedge clk);
        check("re2_off", rdata2, 32'h0);

        // Same-cycle bypass, then committed value.
        next_cycle();
        idle();
        wb_wreg = 1; wb_dest_addr = 7; wb_dest_data = 32'hA5A5A5A5;
        re1 = 1; raddr1 = 7; re2 = 1; raddr2 = 7;
        @(negedge clk);
        check("bypass_p1", rdata1, 32'hA5A5A5A5);
        check("bypass_p2", rdata2, 32'hA5A5A5A5);
        next_cycle();
        wb_wreg = 0;
        @(negedge clk);
        check("bypass_held", rdata1, 32'hA5A5A5A5);

        // r0 stays zero.
        next_cycle();
        idle();
        wb_wreg = 1; wb_dest_addr = 0; wb_dest_data = 32'hFFFFFFFF;
        re1 = 1; raddr1 = 0;
        @(negedge clk);
        check("r0_same", rdata1, 32'h0);
        next_cycle();
        wb_wreg = 0;
        @(negedge clk);
        check("r0_next", rdata1, 32'h0);

        // HI/LO bypass and hold, concurrent with a GPR write.
        next_cycle();
        idle();
        wb_whilo = 1; wb_hi = 32'h11111111; wb_lo = 32'h22222222;
        wb_wreg = 1; wb_dest_addr = 12; wb_dest_data = 32'hCAFEF00D;
        @(negedge clk);
        check("hilo_byp_hi", hi_o, 32'h11111111);
        check("hilo_byp_lo", lo_o, 32'h22222222);
        next_cycle();
        idle();
        re1 = 1; raddr1 = 12;
        @(negedge clk);
        check("hilo_hold_hi", hi_o, 32'h11111111);
        check("hilo_hold_lo", lo_o, 32'h22222222);
        check("indep_gpr", rdata1, 32'hCAFEF00D);

        // Writes coincident with reset are lost.
        next_cycle();
        idle();
        rst = 1;
        wb_wreg = 1; wb_dest_addr = 9; wb_dest_data = 32'h55;
        wb_whilo = 1; wb_hi = 32'h33; wb_lo = 32'h44;
        re1 = 1; raddr1 = 9;
        @(negedge clk);
        check("rst_hi_forced", hi_o, 32'h0);
        next_cycle();
        idle();
        rst = 0;
        re1 = 1; raddr1 = 9; re2 = 1; raddr2 = 3;
        @(negedge clk);
        check("rst_wr_lost", rdata1, 32'h0);
        check("rst_cleared_r3", rdata2, 32'h0);
        check("rst_wr_lost_hi", hi_o, 32'h0);
        check("rst_wr_lost_lo", lo_o, 32'h0);

        // Randomised traffic, narrow address range to force collisions.
        for (int c = 0; c < 3000; c++) begin
            next_cycle();
            rst          = ($urandom_range(0, 99) == 0);
            wb_wreg      = $urandom_range(0, 1);
            wb_dest_addr = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            wb_dest_data = $urandom;
            wb_whilo     = ($urandom_range(0, 3) == 0);
            wb_hi        = $urandom;
            wb_lo        = $urandom;
            re1          = ($urandom_range(0, 4) != 0);
            raddr1       = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            re2          = ($urandom_range(0, 4) != 0);
            raddr2       = ($urandom_range(0, 1) != 0) ? raddr1 : 5'($urandom_range(0, 7));
            if (!re1 && $urandom_range(0, 3) == 0) raddr1 = 'x;
        end

        next_cycle();
        idle();
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back consumer of the MEM/WB pipeline register.
- Holds the 32x32 general-purpose register file (GPR) and the HI/LO special-register pair.
- Accepts one GPR write and one HI/LO write per cycle from the WB stage.
- Serves two GPR read ports to ID and one HI/LO read port to EX, each with same-cycle write-through bypass.

Parameters:
- DATA_W, 32, width of GPR and HI/LO data.
- ADDR_W, 5, GPR address width.
- NUM_REGS, 32, number of GPRs; must equal 2**ADDR_W.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- wb_wreg  in  1  GPR write enable from WB.
- wb_dest_addr  in  ADDR_W  GPR write address.
- wb_dest_data  in  DATA_W  GPR write data.
- wb_whilo  in  1  HI/LO write enable from WB.
- wb_hi  in  DATA_W  HI write data.
- wb_lo  in  DATA_W  LO write data.
- re1  in  1  read enable, port 1.
- raddr1  in  ADDR_W  read address, port 1.
- rdata1  out  DATA_W  read data, port 1.
- re2  in  1  read enable, port 2.
- raddr2  in  ADDR_W  read address, port 2.
- rdata2  out  DATA_W  read data, port 2.
- hi_o  out  DATA_W  current HI, bypassed.
- lo_o  out  DATA_W  current LO, bypassed.

Behaviour:
- Storage: regs[0..NUM_REGS-1], hi_q, lo_q; all DATA_W wide.
- Reset: while rst=1 at a rising edge, every regs[i], hi_q and lo_q clear to 0. The write inputs are ignored on that edge.
- Outputs during reset: while rst=1, rdata1, rdata2, hi_o and lo_o are driven to 0 combinationally, whatever the storage or write inputs hold.
- GPR write: on a rising edge with rst=0 and wb_wreg=1 and wb_dest_addr!=0, regs[wb_dest_addr] <= wb_dest_data.
- r0: writes to address 0 are dropped silently. regs[0] reads as 0 at all times.
- HI/LO write: on a rising edge with rst=0 and wb_whilo=1, hi_q <= wb_hi and lo_q <= wb_lo together. There is no single-half write.
- GPR read: combinational, zero cycles latency. Priority, for each port n independently:
  1. rst=1 -> 0
  2. raddrn=0 -> 0
  3. ren=1 and wb_wreg=1 and wb_dest_addr=raddrn -> wb_dest_data (write-through bypass)
  4. ren=1 -> regs[raddrn]
  5. ren=0 -> 0
- Both ports may read the same address, including the address being written; both then return the bypassed value.
- HI/LO read:
  - rst=1 -> hi_o = lo_o = 0.
  - wb_whilo=1 -> hi_o = wb_hi, lo_o = wb_lo (bypass).
  - Otherwise hi_o = hi_q, lo_o = lo_q.
- Independence: a GPR write and a HI/LO write in the same cycle are independent and both commit.
- Reset mid-stream: a write presented in the same cycle as rst=1 is lost; storage is 0 after that edge.
- No stall input: WB never stalls. Holding wb_wreg=1 for several cycles rewrites the same value each cycle, which is harmless.
- Unknown inputs: X on raddr while ren=0 must not propagate to rdata.

Decomposition:
- Shared defines/package:
  - RstEnable, WriteEnable, ReadEnable, ZeroWord.
  - RegBus, RegAddrBus, RegNum, NOPRegAddr.
  - These are the same constants the pipeline registers use; no local redefinition.
- One sub-module: hilo_reg, holding hi_q/lo_q, the write logic and the HI/LO bypass mux.
- The GPR array and read muxes stay in wb_regfile.

Test Plan:
- Reset check: hold rst=1 for 2 cycles with wb_wreg=1, addr=5, data=0xDEADBEEF. Then release rst and read port 1 with re1=1, raddr1=5 -> rdata1=0. hi_o=lo_o=0.
- Write then read: write addr=3, data=0x12345678. Next cycle read raddr1=3, raddr2=3 -> both 0x12345678. With re2=0 -> rdata2=0.
- Write-through bypass: in one cycle, wb_wreg=1, addr=7, data=0xA5A5A5A5 and raddr1=7 -> rdata1=0xA5A5A5A5 in the same cycle. After the edge, with wb_wreg=0 -> still 0xA5A5A5A5.
- r0 immutability: write addr=0, data=0xFFFFFFFF. Same cycle and next cycle, raddr1=0 -> rdata1=0.
- HI/LO update: wb_whilo=1, hi=0x11111111, lo=0x22222222 -> hi_o/lo_o show these same cycle. Next cycle wb_whilo=0 -> values held.
- Simultaneous write and reset: wb_wreg=1, addr=9, data=0x55 and wb_whilo=1 with rst=1 on the same edge. After release, raddr1=9 -> 0 and hi_o=lo_o=0.
